// File: rtl/cnv_wr_axi_master_pkg.sv
// Shared AXI constants, 4KB page helper and burst descriptor type for the conv write master.
// Latency: none (types and constants only). Backpressure: not applicable.
package cnv_wr_axi_master_pkg;

   localparam logic [2:0]  SIZE_16B     = 3'b100;
   localparam logic [1:0]  BURST_INCR   = 2'b01;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam int          CNV_ADDR_W   = 32;
   localparam logic [11:0] PAGE_4K_MASK = 12'hFFF;

   typedef struct packed {
      logic [CNV_ADDR_W-1:0] addr;
      logic [7:0]            len;
   } cnv_desc_t;

   // An AXI burst may not cross a 4KB page, so a page-aligned beat always starts a new burst.
   function automatic logic page_start(input logic [11:0] addr_lo);
      return (addr_lo & PAGE_4K_MASK) == 12'h000;
   endfunction

endpackage

// File: rtl/cnv_wr_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on pop_dat whenever empty is low.
// Latency: 1 cycle push to visible head. Backpressure: pushes while full and pops while empty are ignored.
module cnv_wr_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             core_clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [2**AW];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (AW+1)'(2**AW));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge core_clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            cnt <= cnt + 1'b1;
         else if (do_pop && !do_push)
            cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge core_clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/cnv_wr_axi_master.sv
// Packs the conv output beat stream into AXI4 INCR write bursts; idle-timeout close under CNV_WR_IDLE_FLUSH_EN.
// Latency: AW valid 2 cycles after the beat that closes a burst; W beats follow their AW handshake.
// Backpressure: input cannot stall; beats are dropped (O_ovf) when the data or descriptor FIFO is full.
module cnv_wr_axi_master
   import cnv_wr_axi_master_pkg::*;
#(
   parameter int AXIWIDTH  = 128,
   parameter int ADDRWIDTH = CNV_ADDR_W,
   parameter int BURST_LEN = 16,
   parameter int DFIFO_AW  = 9,
   parameter int AFIFO_AW  = 5,
   parameter int MAX_OUTST = 8,
   parameter int IDLE_CYC  = 64
) (
   input  logic                  I_clk,
   input  logic                  I_rst_n,
   input  logic                  I_ap_start,
   input  logic [AXIWIDTH-1:0]   I_cnv_data,
   input  logic                  I_cnv_dv,
   input  logic [ADDRWIDTH-1:0]  I_wr_DDRaddr,
   input  logic                  I_flush,
   output logic [ADDRWIDTH-1:0]  O_awaddr,
   output logic [7:0]            O_awlen,
   output logic                  O_awvalid,
   input  logic                  I_awready,
   output logic [2:0]            O_awsize,
   output logic [1:0]            O_awburst,
   output logic [AXIWIDTH-1:0]   O_wdata,
   output logic [AXIWIDTH/8-1:0] O_wstrb,
   output logic                  O_wlast,
   output logic                  O_wvalid,
   input  logic                  I_wready,
   input  logic [1:0]            I_bresp,
   input  logic                  I_bvalid,
   output logic                  O_bready,
   output logic                  O_busy,
   output logic                  O_done,
   output logic                  O_ovf,
   output logic                  O_bresp_err
);

   localparam int CNT_W  = $clog2(BURST_LEN) + 1;
   localparam int OST_W  = $clog2(MAX_OUTST) + 1;
   localparam int IDLE_W = $clog2(IDLE_CYC) + 1;
   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_DATA = 1'b1;
`ifdef CNV_WR_IDLE_FLUSH_EN
   localparam bit IDLE_EN = 1'b1;
`else
   localparam bit IDLE_EN = 1'b0;
`endif

   logic                 open, open_n, close_pend, close_pend_n, drain_pend, drained;
   logic [ADDRWIDTH-1:0] start_addr, start_n, next_addr, next_n, beat_addr;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic                 accept, append, idle_hit;
   logic [IDLE_W-1:0]    idle_cnt;

   cnv_desc_t            desc_in, desc_head;
   logic                 afifo_push, afifo_pop, afifo_full, afifo_empty;
   logic                 dfifo_pop, dfifo_full, dfifo_empty;
   logic [AXIWIDTH-1:0]  dfifo_head;
   logic                 lq_pop, lq_empty;
   logic [7:0]           lq_head;

   logic                 aw_vld, aw_load, aw_hs, b_hs, w_hs, w_last;
   logic [ADDRWIDTH-1:0] aw_addr;
   logic [7:0]           aw_len, w_len, w_beat;
   logic [0:0]           w_state;
   logic [OST_W-1:0]     outst;
   logic                 done_q, ovf_q, berr_q;

   logic [DFIFO_AW:0]    dfifo_cnt_unused;
   logic [AFIFO_AW:0]    afifo_cnt_unused, lq_cnt_unused;
   logic                 lq_full_unused, addr_lsb_unused;

   assign addr_lsb_unused = ^I_wr_DDRaddr[3:0];
   assign beat_addr = {I_wr_DDRaddr[ADDRWIDTH-1:4], 4'b0000};
   assign accept    = I_cnv_dv && !dfifo_full && !afifo_full;
   assign append    = open && (beat_addr == next_addr) && (cnt < CNT_W'(BURST_LEN))
                      && !page_start(beat_addr[11:0]);
   assign idle_hit  = IDLE_EN && open && !accept && (idle_cnt == IDLE_W'(IDLE_CYC - 1));

   // A beat may push one descriptor; a flush/idle close needing a second push waits a cycle.
   always_comb begin
      open_n       = open;
      start_n      = start_addr;
      next_n       = next_addr;
      cnt_n        = cnt;
      afifo_push   = 1'b0;
      desc_in      = '0;
      close_pend_n = close_pend || I_flush || idle_hit;
      if (accept) begin
         if (append) begin
            cnt_n  = cnt + 1'b1;
            next_n = beat_addr + ADDRWIDTH'(16);
         end else begin
            if (open) begin
               afifo_push = 1'b1;
               desc_in    = '{addr: start_addr, len: 8'(cnt) - 8'd1};
            end
            open_n  = 1'b1;
            start_n = beat_addr;
            next_n  = beat_addr + ADDRWIDTH'(16);
            cnt_n   = CNT_W'(1);
         end
         if (cnt_n == CNT_W'(BURST_LEN)) begin
            afifo_push = 1'b1;
            desc_in    = '{addr: start_n, len: 8'(cnt_n) - 8'd1};
            open_n     = 1'b0;
         end
      end
      if (close_pend_n && open_n && !afifo_push && !afifo_full) begin
         afifo_push   = 1'b1;
         desc_in      = '{addr: start_n, len: 8'(cnt_n) - 8'd1};
         open_n       = 1'b0;
         close_pend_n = 1'b0;
      end else if (!open_n) begin
         close_pend_n = 1'b0;
      end
   end

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         open       <= 1'b0;
         close_pend <= 1'b0;
         start_addr <= '0;
         next_addr  <= '0;
         cnt        <= '0;
         idle_cnt   <= '0;
      end else begin
         open       <= open_n;
         close_pend <= close_pend_n;
         start_addr <= start_n;
         next_addr  <= next_n;
         cnt        <= cnt_n;
         if (accept || !open)
            idle_cnt <= '0;
         else if (idle_cnt != IDLE_W'(IDLE_CYC - 1))
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

   cnv_wr_sync_fifo #(.WIDTH(AXIWIDTH), .AW(DFIFO_AW)) u_dfifo (
      .core_clk (I_clk),
      .rst_n    (I_rst_n),
      .push     (accept),
      .push_dat (I_cnv_data),
      .pop      (dfifo_pop),
      .pop_dat  (dfifo_head),
      .full     (dfifo_full),
      .empty    (dfifo_empty),
      .count    (dfifo_cnt_unused)
   );

   cnv_wr_sync_fifo #(.WIDTH($bits(cnv_desc_t)), .AW(AFIFO_AW)) u_afifo (
      .core_clk (I_clk),
      .rst_n    (I_rst_n),
      .push     (afifo_push),
      .push_dat (desc_in),
      .pop      (afifo_pop),
      .pop_dat  (desc_head),
      .full     (afifo_full),
      .empty    (afifo_empty),
      .count    (afifo_cnt_unused)
   );

   cnv_wr_sync_fifo #(.WIDTH(8), .AW(AFIFO_AW)) u_lenq (
      .core_clk (I_clk),
      .rst_n    (I_rst_n),
      .push     (aw_hs),
      .push_dat (aw_len),
      .pop      (lq_pop),
      .pop_dat  (lq_head),
      .full     (lq_full_unused),
      .empty    (lq_empty),
      .count    (lq_cnt_unused)
   );

   // AW is registered out of the descriptor FIFO so it stays stable while awready is low.
   assign aw_load   = !aw_vld && !afifo_empty && (outst < OST_W'(MAX_OUTST));
   assign afifo_pop = aw_load;
   assign aw_hs     = aw_vld && I_awready;
   assign b_hs      = I_bvalid && (outst != '0);

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         aw_vld  <= 1'b0;
         aw_addr <= '0;
         aw_len  <= '0;
         outst   <= '0;
      end else begin
         if (aw_load) begin
            aw_vld  <= 1'b1;
            aw_addr <= desc_head.addr;
            aw_len  <= desc_head.len;
         end else if (aw_hs) begin
            aw_vld <= 1'b0;
         end
         if (aw_hs && !b_hs)
            outst <= outst + 1'b1;
         else if (b_hs && !aw_hs)
            outst <= outst - 1'b1;
      end
   end

   assign lq_pop    = (w_state == W_IDLE) && !lq_empty;
   assign w_hs      = (w_state == W_DATA) && I_wready;
   assign w_last    = (w_state == W_DATA) && (w_beat == w_len);
   assign dfifo_pop = w_hs;

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         w_state <= W_IDLE;
         w_len   <= '0;
         w_beat  <= '0;
      end else begin
         case (w_state)
            W_IDLE: if (!lq_empty) begin
               w_state <= W_DATA;
               w_len   <= lq_head;
               w_beat  <= '0;
            end
            W_DATA: if (I_wready) begin
               w_beat <= w_beat + 1'b1;
               if (w_last) w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   assign drained = !open && !close_pend && afifo_empty && !aw_vld && lq_empty
                    && (w_state == W_IDLE) && (outst == '0);

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         drain_pend <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         berr_q     <= 1'b0;
      end else begin
         done_q <= drain_pend && drained;
         if (I_flush)
            drain_pend <= 1'b1;
         else if (drain_pend && drained)
            drain_pend <= 1'b0;
         if (I_ap_start) begin
            ovf_q  <= 1'b0;
            berr_q <= 1'b0;
         end
         if (I_cnv_dv && !accept) ovf_q <= 1'b1;
         if (b_hs && (I_bresp != RESP_OKAY)) berr_q <= 1'b1;
      end
   end

   assign O_awaddr    = aw_addr;
   assign O_awlen     = aw_len;
   assign O_awvalid   = aw_vld;
   assign O_awsize    = SIZE_16B;
   assign O_awburst   = BURST_INCR;
   assign O_wdata     = dfifo_head;
   assign O_wstrb     = '1;
   assign O_wlast     = w_last;
   assign O_wvalid    = (w_state == W_DATA);
   assign O_bready    = 1'b1;
   assign O_busy      = !dfifo_empty || open || close_pend || !afifo_empty || aw_vld || !lq_empty
                        || (w_state != W_IDLE) || (outst != '0) || drain_pend;
   assign O_done      = done_q;
   assign O_ovf       = ovf_q;
   assign O_bresp_err = berr_q;

endmodule
